ysyx_041461_booth_mul_seq: RTL and testbench

Iterative radix-4 Booth multiplier for the EXU's M-extension path. It retires one Booth digit (two multiplier bits) per cycle into a 2*XLEN accumulator. It supports signed×signed, signed×unsigned and unsigned×unsigned operands, which covers MUL/MULH/MULHSU/MULHU, and returns the full product as hi/lo halves. Valid/ready handshakes are used on both sides, with a flush input for pipeline kills.

---
 rtl/ysyx_041461_booth_mul_seq.sv | 151 +++++++++++++++
 tb/tb_ysyx_041461_booth_mul_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_booth_mul_seq.sv
// ---------------------------------------------------------------------------------------------
// ysyx_041461_booth_mul_seq
// Iterative radix-4 Booth multiplier. Retires one Booth digit (two multiplier bits) per cycle
// into a 2*XLEN accumulator and returns the full product as hi/lo halves.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid             in_ready   block can accept operands (IDLE)
//   flush      abort and discard          x_signed   multiplicand is signed
//   y_signed   multiplier is signed       mul_x      multiplicand (rs1)
//   mul_y      multiplier (rs2)           out_valid  result valid (DONE)
//   out_ready  consumer accepts result    result_hi  product [2*XLEN-1:XLEN]
//   result_lo  product [XLEN-1:0]
// ---------------------------------------------------------------------------------------------
module ysyx_041461_booth_mul_seq #(
   parameter int unsigned XLEN      = 64,
   parameter bit          ZERO_SKIP = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic            x_signed,
   input  logic            y_signed,
   input  logic [XLEN-1:0] mul_x,
   input  logic [XLEN-1:0] mul_y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_hi,
   output logic [XLEN-1:0] result_lo
);

   localparam int unsigned PW   = 2 * XLEN;
   localparam int unsigned ITER = XLEN / 2 + 1;
   localparam int unsigned CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          r_state, w_state_nxt;
   // Multiplicand pre-shifted by 2i, so the current digit's term is r_x or r_x << 1.
   logic [PW-1:0]   r_x, w_x_nxt;
   // Multiplier as {ext, ext, y, y[-1]=0}, shifted right by 2 per digit; digit is r_y[2:0].
   logic [XLEN+2:0] r_y, w_y_nxt;
   logic [PW-1:0]   r_acc, w_acc_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [XLEN-1:0] r_hi, w_hi_nxt;
   logic [XLEN-1:0] r_lo, w_lo_nxt;

   logic [PW-1:0]   w_term;
   logic            w_cin;
   logic [PW-1:0]   w_sum;
   logic            w_zero;

   // Booth digit recode; negative digits use ~term with carry-in 1 in the same add.
   always_comb begin
      w_term = '0;
      w_cin  = 1'b0;
      unique case (r_y[2:0])
         3'b001, 3'b010: w_term = r_x;
         3'b011:         w_term = r_x << 1;
         3'b100: begin
            w_term = ~(r_x << 1);
            w_cin  = 1'b1;
         end
         3'b101, 3'b110: begin
            w_term = ~r_x;
            w_cin  = 1'b1;
         end
         default:        w_term = '0;
      endcase
   end

   assign w_sum  = r_acc + w_term + {{(PW - 1){1'b0}}, w_cin};
   assign w_zero = ZERO_SKIP && ((mul_x == '0) || (mul_y == '0));

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;

      if (flush) begin
         w_state_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (in_valid) begin
                  w_x_nxt   = {{XLEN{x_signed & mul_x[XLEN-1]}}, mul_x};
                  w_y_nxt   = {{2{y_signed & mul_y[XLEN-1]}}, mul_y, 1'b0};
                  w_acc_nxt = '0;
                  w_cnt_nxt = '0;
                  if (w_zero) begin
                     w_state_nxt = StDone;
                     w_hi_nxt    = '0;
                     w_lo_nxt    = '0;
                  end else begin
                     w_state_nxt = StBusy;
                  end
               end
            end
            StBusy: begin
               w_x_nxt   = r_x << 2;
               w_y_nxt   = r_y >> 2;
               w_acc_nxt = w_sum;
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = StDone;
                  w_hi_nxt    = w_sum[PW-1:XLEN];
                  w_lo_nxt    = w_sum[XLEN-1:0];
               end
            end
            StDone: begin
               if (out_ready) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_x     <= '0;
         r_y     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StDone);
   assign result_hi = r_hi;
   assign result_lo = r_lo;

endmodule

// File: tb/tb_ysyx_041461_booth_mul_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_ysyx_041461_booth_mul_seq
// Directed bench for the radix-4 Booth multiplier (XLEN=64). Expected products come from a
// 128-bit reference multiply and travel through a scoreboard queue.
// ---------------------------------------------------------------------------------------------
module tb_ysyx_041461_booth_mul_seq;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ITER = XLEN / 2 + 1;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic            x_signed;
   logic            y_signed;
   logic [XLEN-1:0] mul_x;
   logic [XLEN-1:0] mul_y;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result_hi;
   logic [XLEN-1:0] result_lo;

   int total;
   int bad;
   logic [2*XLEN-1:0] sb_q[$];

   ysyx_041461_booth_mul_seq #(
      .XLEN      (XLEN),
      .ZERO_SKIP (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .x_signed  (x_signed),
      .y_signed  (y_signed),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result_hi (result_hi),
      .result_lo (result_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*XLEN-1:0] ref_mul(input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y,
                                                 input logic xs, input logic ys);
      logic [2*XLEN-1:0] xe;
      logic [2*XLEN-1:0] ye;
      xe = xs ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
      ye = ys ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
      return xe * ye;
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation, wait for out_valid, hold out_ready low for hold cycles, then hand off.
   task automatic do_mul(input string tag, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic xs, input logic ys, input int exp_lat, input int hold);
      logic [2*XLEN-1:0] exp_p;
      logic [XLEN-1:0]   hi0;
      logic [XLEN-1:0]   lo0;
      int n;
      mul_x    = x;
      mul_y    = y;
      x_signed = xs;
      y_signed = ys;
      in_valid = 1'b1;
      sb_q.push_back(ref_mul(x, y, xs, ys));
      tick();
      in_valid = 1'b0;
      mul_x    = $urandom();
      mul_y    = $urandom();
      // n = edges after the accept edge until out_valid is seen
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
      exp_p = sb_q.pop_front();
      chk({tag, "_hi"}, result_hi, exp_p[2*XLEN-1:XLEN]);
      chk({tag, "_lo"}, result_lo, exp_p[XLEN-1:0]);
      hi0 = result_hi;
      lo0 = result_lo;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, "_hold_hi"}, result_hi, hi0);
         chk({tag, "_hold_lo"}, result_lo, lo0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_after_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_after_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int seen_valid;
      logic [XLEN-1:0] rx;
      logic [XLEN-1:0] ry;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      x_signed  = 1'b0;
      y_signed  = 1'b0;
      mul_x     = '0;
      mul_y     = '0;
      out_ready = 1'b0;

      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_hi", result_hi, 64'd0);
      chk("rst_lo", result_lo, 64'd0);
      rst_n = 1'b1;
      tick();

      do_mul("uu_3x5", 64'd3, 64'd5, 1'b0, 1'b0, ITER, 0);
      chk("uu_3x5_const_lo", result_lo, 64'd15);
      do_mul("ss_m1xm1", '1, '1, 1'b1, 1'b1, ITER, 0);
      chk("ss_m1xm1_const_lo", result_lo, 64'd1);
      chk("ss_m1xm1_const_hi", result_hi, 64'd0);
      do_mul("uu_m1xm1", '1, '1, 1'b0, 1'b0, ITER, 0);
      chk("uu_m1xm1_const_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
      do_mul("su_m1xm1", '1, '1, 1'b1, 1'b0, ITER, 0);
      chk("su_m1xm1_const_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
      do_mul("ss_7x6", 64'd7, 64'd6, 1'b1, 1'b1, ITER, 0);
      chk("ss_7x6_const_lo", result_lo, 64'd42);
      do_mul("ss_m7x6", -64'sd7, 64'd6, 1'b1, 1'b1, ITER, 0);
      chk("ss_m7x6_const_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFD6);
      chk("ss_m7x6_const_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
      do_mul("us_5xm3", 64'h8000_0000_0000_0005, -64'sd3, 1'b0, 1'b1, ITER, 0);

      for (int k = 0; k < 4; k++) begin
         rx = {$urandom(), $urandom()};
         ry = {$urandom(), $urandom()};
         do_mul($sformatf("rnd%0d", k), rx, ry, k[0], k[1], ITER, 0);
      end

      // zero operand with backpressure
      do_mul("zero_bp", 64'd0, 64'd123, 1'b0, 1'b0, 0, 5);
      chk("zero_bp_const_lo", result_lo, 64'd0);

      // flush at BUSY cycle 10; operands offered alongside the flush must be dropped
      mul_x    = 64'd100;
      mul_y    = 64'd3;
      x_signed = 1'b0;
      y_signed = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      mul_x    = 64'd9;
      mul_y    = 64'd9;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      seen_valid = 0;
      for (int i = 0; i < ITER + 5; i++) begin
         tick();
         if (out_valid) seen_valid++;
      end
      chk("flush_no_result", 64'(seen_valid), 64'd0);
      do_mul("post_flush_2x2", 64'd2, 64'd2, 1'b0, 1'b0, ITER, 0);
      chk("post_flush_const_lo", result_lo, 64'd4);

      // asynchronous reset in the middle of BUSY
      mul_x    = 64'd11;
      mul_y    = 64'd13;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_hi", result_hi, 64'd0);
      chk("arst_lo", result_lo, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_mul("post_rst", 64'd11, 64'd13, 1'b0, 1'b0, ITER, 0);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
